// File: rtl/dmem_arb_pkg.sv
// ============================================================================
// dmem_arb_pkg : shared state encoding and default sizes for dmem_arbiter.
// Rev 1.0
// ============================================================================
`default_nettype none

package dmem_arb_pkg;

    localparam int DEF_LEN_W          = 5;
    localparam int DEF_MAX_CPU_STREAK = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DONE  = 2'd2
    } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/dmem_burst_ctr.sv
// ============================================================================
// dmem_burst_ctr : latched burst descriptor plus beat counter; yields beat address.
// Rev 1.0
// ============================================================================
`default_nettype none

module dmem_burst_ctr
    import dmem_arb_pkg::*;
#(
    parameter int WORD_LEN = 32,
    parameter int LEN_W    = DEF_LEN_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [WORD_LEN-1:0] base,
    input  logic [LEN_W-1:0]    len,
    input  logic                we,
    input  logic                advance,
    output logic [WORD_LEN-1:0] beat_addr,
    output logic                last_beat,
    output logic                burst_we
);

    logic [WORD_LEN-1:0] base_q;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    cnt_q;
    logic                we_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_q <= '0;
            len_q  <= '0;
            cnt_q  <= '0;
            we_q   <= 1'b0;
        end else if (load) begin
            base_q <= base;
            len_q  <= len;
            we_q   <= we;
            cnt_q  <= '0;
        end else if (advance) begin
            cnt_q  <= cnt_q + 1'b1;
        end
    end

    // Word-aligned offset; the add wraps naturally at 2**WORD_LEN.
    assign beat_addr = base_q + {{(WORD_LEN-LEN_W-2){1'b0}}, cnt_q, 2'b00};
    assign last_beat = (cnt_q == (len_q - 1'b1));
    assign burst_we  = we_q;

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// dmem_arbiter : shares the data-memory port between the CPU MEM stage and a
// burst DMA. Optional fairness throttling via macro DMEM_ARB_FAIR_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int WORD_LEN = 32,
    parameter int LEN_W    = DEF_LEN_W
`ifdef DMEM_ARB_FAIR_EN
    ,
    parameter int MAX_CPU_STREAK = DEF_MAX_CPU_STREAK
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [WORD_LEN-1:0] cpu_addr,
    input  logic [WORD_LEN-1:0] cpu_wdata,
    output logic                cpu_ack,
    output logic                cpu_stall,
    output logic [WORD_LEN-1:0] cpu_rdata,
    input  logic                dma_req,
    input  logic                dma_we,
    input  logic [WORD_LEN-1:0] dma_addr,
    input  logic [LEN_W-1:0]    dma_len,
    input  logic [WORD_LEN-1:0] dma_wdata,
    output logic                dma_wready,
    output logic [WORD_LEN-1:0] dma_rdata,
    output logic                dma_rvalid,
    output logic                dma_busy,
    output logic                dma_done,
    output logic                mem_writeEn,
    output logic                mem_readEn,
    output logic [WORD_LEN-1:0] mem_address,
    output logic [WORD_LEN-1:0] mem_dataIn,
    input  logic [WORD_LEN-1:0] mem_dataOut
);

    arb_state_e          state_q, state_d;
    logic                load;
    logic                dma_beat;
    logic                force_dma;
    logic                last_beat;
    logic                burst_we;
    logic [WORD_LEN-1:0] beat_addr;

    dmem_burst_ctr #(
        .WORD_LEN (WORD_LEN),
        .LEN_W    (LEN_W)
    ) u_burst_ctr (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .base      (dma_addr),
        .len       (dma_len),
        .we        (dma_we),
        .advance   (dma_beat),
        .beat_addr (beat_addr),
        .last_beat (last_beat),
        .burst_we  (burst_we)
    );

`ifdef DMEM_ARB_FAIR_EN
    localparam int SW = $clog2(MAX_CPU_STREAK + 1);
    logic [SW-1:0] streak_q;

    assign force_dma = cpu_req && (state_q == ST_BURST) &&
                       (streak_q == SW'(MAX_CPU_STREAK));

    // In BURST a cycle without a DMA beat but with cpu_req is a CPU win.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            streak_q <= '0;
        end else if (dma_beat) begin
            streak_q <= '0;
        end else if (cpu_req && (state_q == ST_BURST)) begin
            streak_q <= streak_q + 1'b1;
        end
    end
`else
    assign force_dma = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (dma_req) begin
                    if (dma_len != '0) begin
                        state_d = ST_BURST;
                        load    = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_BURST: begin
                if (dma_beat && last_beat) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign cpu_ack   = cpu_req && !force_dma;
    assign cpu_stall = cpu_req && !cpu_ack;
    assign dma_beat  = (state_q == ST_BURST) && !cpu_ack;

    always_comb begin
        mem_writeEn = 1'b0;
        mem_readEn  = 1'b0;
        mem_address = '0;
        mem_dataIn  = '0;
        if (cpu_ack) begin
            mem_writeEn = cpu_we;
            mem_readEn  = !cpu_we;
            mem_address = cpu_addr;
            mem_dataIn  = cpu_wdata;
        end else if (dma_beat) begin
            mem_writeEn = burst_we;
            mem_readEn  = !burst_we;
            mem_address = beat_addr;
            mem_dataIn  = burst_we ? dma_wdata : '0;
        end
    end

    assign cpu_rdata  = cpu_ack ? mem_dataOut : '0;
    assign dma_wready = dma_beat && burst_we;
    assign dma_busy   = (state_q != ST_IDLE);
    assign dma_done   = (state_q == ST_DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dma_rvalid <= 1'b0;
            dma_rdata  <= '0;
        end else begin
            dma_rvalid <= dma_beat && !burst_we;
            if (dma_beat && !burst_we) begin
                dma_rdata <= mem_dataOut;
            end
        end
    end

endmodule

`default_nettype wire
